keypad_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single home-security core's command/digit interface between two keypads (front door = keypad 0, back door = keypad 1). A keypad owns the core for one complete transaction: one command cycle followed by exactly three digit strobes. Stalled transactions are timed out and flushed with invalid digits so the core always returns to a safe state. Sits between the keypad front-ends and the security core.

---
 rtl/keypad_arbiter_if.sv | 33 +++
 rtl/keypad_arbiter.sv | 144 ++++++++++++++
 tb/tb_keypad_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_arbiter_if.sv
// keypad_arbiter_if: keypad-side request/digit signals and core-side command/digit signals
// shared by the two keypads and the security core. Revision 1.0.
`default_nettype none

interface keypad_arbiter_if;
  logic       req0;
  logic       req1;
  logic [1:0] cmd0;
  logic [1:0] cmd1;
  logic       dstb0;
  logic       dstb1;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] command;
  logic       input_digit;
  logic [3:0] digit;
  logic       abort;
  logic [1:0] deny;

  modport master (
    output req0, req1, cmd0, cmd1, dstb0, dstb1, digit0, digit1,
    input  grant, busy, command, input_digit, digit, abort, deny
  );

  modport slave (
    input  req0, req1, cmd0, cmd1, dstb0, dstb1, digit0, digit1,
    output grant, busy, command, input_digit, digit, abort, deny
  );
endinterface

`default_nettype wire

// File: rtl/keypad_arbiter.sv
// keypad_arbiter: round-robin owner of the security core for one command + three digits,
// with timeout abort and 0xF digit flush. Revision 1.0.
`default_nettype none

module keypad_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic            clk,
  input  logic            reset,
  keypad_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_DIGITS  = 3'd2,
    S_FLUSH   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic             owner, owner_n;
  logic             ptr, ptr_n;
  logic [1:0]       dcnt, dcnt_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic [1:0]       grant_n, command_n, deny_n;
  logic             busy_n, input_digit_n, abort_n;
  logic [3:0]       digit_n;

  logic             valid0, valid1, own_dstb;
  logic [3:0]       own_digit;

  assign valid0    = bus.req0 && (bus.cmd0 == 2'd1 || bus.cmd0 == 2'd2);
  assign valid1    = bus.req1 && (bus.cmd1 == 2'd1 || bus.cmd1 == 2'd2);
  assign own_dstb  = owner ? bus.dstb1 : bus.dstb0;
  assign own_digit = owner ? bus.digit1 : bus.digit0;

  always_comb begin
    state_n       = state;
    owner_n       = owner;
    ptr_n         = ptr;
    dcnt_n        = dcnt;
    tcnt_n        = tcnt;
    grant_n       = bus.grant;
    command_n     = 2'd0;
    input_digit_n = 1'b0;
    digit_n       = bus.digit;
    abort_n       = 1'b0;
    // Strobes from a keypad that does not own the core are bounced, never forwarded.
    deny_n        = {bus.dstb1 & bus.busy & ~bus.grant[1],
                     bus.dstb0 & bus.busy & ~bus.grant[0]};

    case (state)
      S_IDLE: begin
        // ptr holds the last owner; on a tie the other keypad wins.
        if (valid0 && (!valid1 || ptr)) begin
          owner_n   = 1'b0;
          grant_n   = 2'b01;
          command_n = bus.cmd0;
          state_n   = S_CMD;
        end else if (valid1) begin
          owner_n   = 1'b1;
          grant_n   = 2'b10;
          command_n = bus.cmd1;
          state_n   = S_CMD;
        end
      end
      S_CMD: begin
        dcnt_n  = 2'd0;
        tcnt_n  = '0;
        state_n = S_DIGITS;
      end
      S_DIGITS: begin
        if (own_dstb) begin
          input_digit_n = 1'b1;
          digit_n       = own_digit;
          dcnt_n        = dcnt + 2'd1;
          tcnt_n        = '0;
          if (dcnt == 2'd2) begin
            grant_n = 2'b00;
            state_n = S_RELEASE;
          end
        end else if (tcnt == TC_LAST) begin
          abort_n = 1'b1;
          state_n = S_FLUSH;
        end else begin
          tcnt_n = tcnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        input_digit_n = 1'b1;
        digit_n       = 4'hF;
        dcnt_n        = dcnt + 2'd1;
        if (dcnt == 2'd2) begin
          grant_n = 2'b00;
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        ptr_n   = owner;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      owner           <= 1'b0;
      ptr             <= 1'b1;
      dcnt            <= 2'd0;
      tcnt            <= '0;
      bus.grant       <= 2'b00;
      bus.busy        <= 1'b0;
      bus.command     <= 2'd0;
      bus.input_digit <= 1'b0;
      bus.digit       <= 4'd0;
      bus.abort       <= 1'b0;
      bus.deny        <= 2'b00;
    end else begin
      state           <= state_n;
      owner           <= owner_n;
      ptr             <= ptr_n;
      dcnt            <= dcnt_n;
      tcnt            <= tcnt_n;
      bus.grant       <= grant_n;
      bus.busy        <= busy_n;
      bus.command     <= command_n;
      bus.input_digit <= input_digit_n;
      bus.digit       <= digit_n;
      bus.abort       <= abort_n;
      bus.deny        <= deny_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_arbiter.sv
// tb_keypad_arbiter: directed scenarios plus random traffic, every output checked each cycle
// against a transaction-level reference model. Revision 1.0.
`default_nettype none

module tb_keypad_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_arbiter_if kif();

  keypad_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the core, where the transaction stands, and expected outputs.
  bit         m_busy, m_first, m_flush, m_rel;
  int         m_owner, m_last, m_done, m_quiet;
  logic [1:0] e_grant, e_cmd, e_deny;
  logic       e_in, e_abort;
  logic [3:0] e_digit;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_flush = 0; m_rel = 0;
    m_owner = 0; m_last = 1; m_done = 0; m_quiet = 0;
    e_grant = 2'b00; e_cmd = 2'd0; e_deny = 2'b00;
    e_in = 1'b0; e_abort = 1'b0; e_digit = 4'd0;
  endtask

  task automatic finish_txn();
    e_grant = 2'b00;
    m_rel   = 1;
  endtask

  task automatic model_step();
    bit         s [2];
    bit         v [2];
    logic [3:0] dg [2];
    logic [1:0] cm [2];
    int         w;
    if (reset) begin
      model_reset();
      return;
    end
    s[0] = kif.dstb0;  s[1] = kif.dstb1;
    dg[0] = kif.digit0; dg[1] = kif.digit1;
    cm[0] = kif.cmd0;  cm[1] = kif.cmd1;
    v[0] = kif.req0 && (cm[0] == 2'd1 || cm[0] == 2'd2);
    v[1] = kif.req1 && (cm[1] == 2'd1 || cm[1] == 2'd2);

    e_deny[0] = s[0] && m_busy && !e_grant[0];
    e_deny[1] = s[1] && m_busy && !e_grant[1];
    e_cmd = 2'd0; e_in = 1'b0; e_abort = 1'b0;

    if (!m_busy) begin
      w = -1;
      if (v[0] && v[1]) w = 1 - m_last;
      else if (v[0]) w = 0;
      else if (v[1]) w = 1;
      if (w >= 0) begin
        m_busy = 1; m_first = 1; m_owner = w;
        e_grant = (w == 0) ? 2'b01 : 2'b10;
        e_cmd = cm[w];
        m_done = 0; m_quiet = 0;
      end
    end else if (m_rel) begin
      m_rel = 0; m_busy = 0; m_last = m_owner;
    end else if (m_first) begin
      m_first = 0; m_done = 0; m_quiet = 0;
    end else if (m_flush) begin
      e_in = 1'b1; e_digit = 4'hF; m_done++;
      if (m_done == 3) begin
        m_flush = 0;
        finish_txn();
      end
    end else if (s[m_owner]) begin
      e_in = 1'b1; e_digit = dg[m_owner]; m_done++; m_quiet = 0;
      if (m_done == 3) finish_txn();
    end else begin
      m_quiet++;
      if (m_quiet == T) begin
        e_abort = 1'b1; m_flush = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("grant", 8'(kif.grant), 8'(e_grant));
    chk("busy", 8'(kif.busy), 8'(m_busy));
    chk("command", 8'(kif.command), 8'(e_cmd));
    chk("input_digit", 8'(kif.input_digit), 8'(e_in));
    chk("abort", 8'(kif.abort), 8'(e_abort));
    chk("deny", 8'(kif.deny), 8'(e_deny));
    if (e_in) chk("digit", 8'(kif.digit), 8'(e_digit));
  endtask

  task automatic cyc(input bit rst,
                     input bit r0, input logic [1:0] c0, input bit s0, input logic [3:0] d0,
                     input bit r1, input logic [1:0] c1, input bit s1, input logic [3:0] d1);
    @(negedge clk);
    reset = rst;
    kif.req0 = r0; kif.cmd0 = c0; kif.dstb0 = s0; kif.digit0 = d0;
    kif.req1 = r1; kif.cmd1 = c1; kif.dstb1 = s1; kif.digit1 = d1;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 0, 4'd0, 0, 2'd0, 0, 4'd0);
  endtask

  task automatic strobe0(input logic [3:0] d);
    cyc(0, 0, 2'd0, 1, d, 0, 2'd0, 0, 4'd0);
  endtask

  task automatic strobe1(input logic [3:0] d);
    cyc(0, 0, 2'd0, 0, 4'd0, 0, 2'd0, 1, d);
  endtask

  initial begin
    model_reset();
    kif.req0 = 0; kif.cmd0 = 0; kif.dstb0 = 0; kif.digit0 = 0;
    kif.req1 = 0; kif.cmd1 = 0; kif.dstb1 = 0; kif.digit1 = 0;
    cyc(1, 0, 2'd0, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    cyc(1, 0, 2'd0, 0, 4'd0, 0, 2'd0, 0, 4'd0);

    // Keypad 0 arm with digits 1,2,4.
    cyc(0, 1, 2'd1, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    idle(1);
    strobe0(4'd1); idle(1); strobe0(4'd2); strobe0(4'd4);
    idle(3);

    // Tie after reset goes to keypad 0, the next tie to keypad 1.
    cyc(1, 0, 2'd0, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    cyc(0, 1, 2'd2, 0, 4'd0, 1, 2'd2, 0, 4'd0);
    idle(1);
    strobe0(4'd3); strobe0(4'd3); strobe0(4'd3);
    idle(2);
    cyc(0, 1, 2'd2, 0, 4'd0, 1, 2'd2, 0, 4'd0);
    idle(1);
    strobe1(4'd6); strobe1(4'd6); strobe1(4'd6);
    idle(2);

    // Keypad 1 sends one digit then stalls: abort and two 0xF flush digits.
    cyc(0, 0, 2'd0, 0, 4'd0, 1, 2'd1, 0, 4'd0);
    idle(1);
    strobe1(4'd5);
    idle(16);

    // Non-owner strobe while keypad 0 owns.
    cyc(0, 1, 2'd2, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    idle(1);
    strobe0(4'd3);
    strobe1(4'd7);
    strobe0(4'd8); strobe0(4'd9);
    idle(3);

    // Reset in the middle of DIGITS, then keypad 1 is served normally.
    cyc(0, 1, 2'd1, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    idle(1);
    strobe0(4'd2);
    idle(1);
    cyc(1, 0, 2'd0, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    cyc(0, 0, 2'd0, 0, 4'd0, 1, 2'd1, 0, 4'd0);
    idle(1);
    strobe1(4'd1); strobe1(4'd2); strobe1(4'd3);
    idle(2);

    // Reserved and empty commands never win.
    cyc(0, 1, 2'd3, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    cyc(0, 1, 2'd0, 0, 4'd0, 1, 2'd3, 0, 4'd0);
    idle(1);

    // Owner strobe lands exactly on the expiry cycle: forwarded, no abort.
    cyc(0, 1, 2'd1, 0, 4'd0, 0, 2'd0, 0, 4'd0);
    idle(1 + T - 1);
    strobe0(4'd9);
    strobe0(4'd8); strobe0(4'd7);
    idle(3);

    // Random traffic, alternating busy and sparse strobe phases to provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      bit sparse;
      sparse = ((i / 150) % 2) == 1;
      cyc($urandom_range(0, 599) == 0,
          $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0),
          4'($urandom_range(0, 15)),
          $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0),
          4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
